// File: rtl/am_rx_pkg.sv
// Shared widths, lock-state encoding and saturation helper for the
// non-coherent AM envelope receiver.
package am_rx_pkg;

    localparam int ENV_W = 15;
    localparam int AM_W  = 16;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Clamp a signed AM_W value into the signed n-bit range; result stays AM_W wide.
    function automatic logic signed [AM_W-1:0] sat_sN(input logic signed [AM_W-1:0] x,
                                                      input int n);
        int hi;
        int lo;
        int xi;
        hi = (1 << (n - 1)) - 1;
        lo = -hi - 1;
        xi = int'(x);
        if (xi > hi)
            xi = hi;
        else if (xi < lo)
            xi = lo;
        return $signed(AM_W'(xi));
    endfunction

endpackage

// File: rtl/am_rx_intdump.sv
// Integrate-and-dump decimator: sums 2^DEC_LOG2 rectified samples and
// emits their mean with a one-cycle valid strobe.
module am_rx_intdump
    import am_rx_pkg::*;
#(
    parameter int DEC_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ENV_W-1:0] sample,
    input  logic             sample_vld,
    output logic [ENV_W-1:0] mean,
    output logic             mean_vld
);

    localparam int ACC_W = ENV_W + DEC_LOG2;

    logic [ACC_W-1:0]    acc_p1;
    logic [DEC_LOG2-1:0] cnt_p1;
    logic [ACC_W-1:0]    sum;

    // Wide enough for a full block of full-scale samples, so no overflow.
    assign sum = acc_p1 + ACC_W'(sample);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1   <= '0;
            cnt_p1   <= '0;
            mean     <= '0;
            mean_vld <= 1'b0;
        end else begin
            mean_vld <= 1'b0;
            if (sample_vld) begin
                cnt_p1 <= cnt_p1 + 1'b1;
                if (&cnt_p1) begin
                    mean     <= sum[ACC_W-1:DEC_LOG2];
                    mean_vld <= 1'b1;
                    acc_p1   <= '0;
                end else begin
                    acc_p1 <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/am_envelope_rx.sv
// Non-coherent AM envelope receiver: rectify, integrate-and-dump, optional DC
// removal (AM_RX_DCBLOCK_EN), lock FSM reporting carrier presence.
module am_envelope_rx
    import am_rx_pkg::*;
#(
    parameter int DEC_LOG2 = 4,
    parameter int OUT_W    = 9,
    parameter int DC_SHIFT = 6,
    parameter int LOCK_THR = 512,
    parameter int LOCK_N   = 8
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic signed [AM_W-1:0]  modulate,
    input  logic                    mod_valid,
    output logic signed [OUT_W-1:0] jidai_out,
    output logic                    jidai_valid,
    output logic [ENV_W-1:0]        envelope,
    output logic                    carrier_ok
);

    localparam int CNT_W = $clog2(LOCK_N + 1);

    // -32768 has no positive counterpart and is clamped to full scale.
    function automatic logic [ENV_W-1:0] rectify(input logic signed [AM_W-1:0] x);
        logic [AM_W-1:0] mag;
        mag = x;
        if (x[AM_W-1])
            mag = ~mag + 1'b1;
        return mag[AM_W-1] ? {ENV_W{1'b1}} : mag[ENV_W-1:0];
    endfunction

    logic [ENV_W-1:0] rect_p0;
    logic             vld_p0;
    logic [ENV_W-1:0] env_p1;
    logic             vld_p1;
    logic [ENV_W-1:0] env_p2;
    logic             vld_p2;

    lock_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             qual;

    // Stage 0: rectifier
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rect_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= mod_valid;
            if (mod_valid)
                rect_p0 <= rectify(modulate);
        end
    end

    // Stage 1: block integration and dump
    am_rx_intdump #(
        .DEC_LOG2 (DEC_LOG2)
    ) u_intdump (
        .clk        (clk_in),
        .rst        (rst),
        .sample     (rect_p0),
        .sample_vld (vld_p0),
        .mean       (env_p1),
        .mean_vld   (vld_p1)
    );

    // Stage 2: envelope register and DC tracker
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            env_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1)
                env_p2 <= env_p1;
        end
    end

`ifdef AM_RX_DCBLOCK_EN
    localparam int DCA_W = ENV_W + DC_SHIFT;

    logic [DCA_W-1:0]       dc_acc;
    logic [ENV_W-1:0]       dc;
    logic signed [AM_W-1:0] ac_p2;

    // Leaky mean: dc_acc settles at 2^DC_SHIFT times the long-run envelope.
    assign dc = dc_acc[DCA_W-1:DC_SHIFT];

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            dc_acc <= '0;
            ac_p2  <= '0;
        end else if (vld_p1) begin
            ac_p2  <= $signed({1'b0, env_p1}) - $signed({1'b0, dc});
            dc_acc <= dc_acc + DCA_W'(env_p1) - DCA_W'(dc);
        end
    end
`endif

    // Stage 3: output registers
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            jidai_valid <= 1'b0;
            envelope    <= '0;
            jidai_out   <= '0;
        end else begin
            jidai_valid <= vld_p2;
            if (vld_p2) begin
                envelope <= env_p2;
`ifdef AM_RX_DCBLOCK_EN
                jidai_out <= OUT_W'(sat_sN(ac_p2 >>> (AM_W - OUT_W), OUT_W));
`else
                jidai_out <= {1'b0, env_p2[ENV_W-1:AM_W-OUT_W]};
`endif
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= SEARCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter tracks envelopes that argue for leaving the current state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        qual      = 1'b0;
        if (vld_p2) begin
            if (state == SEARCH)
                qual = (env_p2 >= ENV_W'(LOCK_THR));
            else
                qual = (env_p2 < ENV_W'(LOCK_THR));
            if (qual) begin
                if (cnt == CNT_W'(LOCK_N - 1)) begin
                    state_nxt = (state == SEARCH) ? LOCKED : SEARCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                cnt_nxt = '0;
            end
        end
    end

    assign carrier_ok = (state == LOCKED);

endmodule

// File: tb/tb_am_envelope_rx.sv
// Directed bench for am_envelope_rx with a scoreboard of expected strobes.
module tb_am_envelope_rx;

    localparam int DEC_LOG2 = 4;
    localparam int OUT_W    = 9;
    localparam int DC_SHIFT = 6;
    localparam int LOCK_THR = 512;
    localparam int LOCK_N   = 8;
    localparam int BLK      = 1 << DEC_LOG2;
    localparam int OMASK    = (1 << OUT_W) - 1;

    logic               clk_in = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] modulate = '0;
    logic               mod_valid = 1'b0;
    logic [OUT_W-1:0]   jidai_out;
    logic               jidai_valid;
    logic [14:0]        envelope;
    logic               carrier_ok;

    am_envelope_rx #(
        .DEC_LOG2 (DEC_LOG2),
        .OUT_W    (OUT_W),
        .DC_SHIFT (DC_SHIFT),
        .LOCK_THR (LOCK_THR),
        .LOCK_N   (LOCK_N)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .modulate    (modulate),
        .mod_valid   (mod_valid),
        .jidai_out   (jidai_out),
        .jidai_valid (jidai_valid),
        .envelope    (envelope),
        .carrier_ok  (carrier_ok)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int env;
        int out;
        int ok;
        int due;
    } exp_t;

    exp_t sbq[$];

    int blk_sum = 0;
    int blk_cnt = 0;
    int m_dc_acc = 0;
    int m_locked = 0;
    int m_cnt = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int abs_sat(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 32767) ? 32767 : a;
    endfunction

    task automatic model_block(input int env);
        exp_t e;
        int dc;
        int ac;
        e.env = env;
`ifdef AM_RX_DCBLOCK_EN
        dc = m_dc_acc >>> DC_SHIFT;
        ac = env - dc;
        m_dc_acc = m_dc_acc + ac;
        ac = ac >>> (16 - OUT_W);
        if (ac > (1 << (OUT_W - 1)) - 1) ac = (1 << (OUT_W - 1)) - 1;
        if (ac < -(1 << (OUT_W - 1))) ac = -(1 << (OUT_W - 1));
        e.out = ac & OMASK;
`else
        dc = 0;
        ac = env >> (16 - OUT_W);
        e.out = ac + dc;
`endif
        if (m_locked == 0) begin
            if (env >= LOCK_THR) begin
                m_cnt++;
                if (m_cnt == LOCK_N) begin
                    m_locked = 1;
                    m_cnt = 0;
                end
            end else m_cnt = 0;
        end else begin
            if (env < LOCK_THR) begin
                m_cnt++;
                if (m_cnt == LOCK_N) begin
                    m_locked = 0;
                    m_cnt = 0;
                end
            end else m_cnt = 0;
        end
        e.ok  = m_locked;
        e.due = cyc + 3;
        sbq.push_back(e);
    endtask

    task automatic send(input int v);
        modulate  = 16'(v);
        mod_valid = 1'b1;
        @(posedge clk_in);
        #1;
        mod_valid = 1'b0;
        blk_sum += abs_sat(v);
        blk_cnt++;
        if (blk_cnt == BLK) begin
            model_block(blk_sum >> DEC_LOG2);
            blk_sum = 0;
            blk_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_block(input int v, input int gap);
        for (int i = 0; i < BLK; i++) begin
            send(v);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        chk("rst_envelope", int'(envelope), 0);
        chk("rst_jidai_out", int'(jidai_out), 0);
        chk("rst_jidai_valid", int'(jidai_valid), 0);
        chk("rst_carrier_ok", int'(carrier_ok), 0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        blk_sum = 0;
        blk_cnt = 0;
        m_dc_acc = 0;
        m_locked = 0;
        m_cnt = 0;
    endtask

    // Scoreboard consumer: every strobe must match the oldest expected block.
    always @(negedge clk_in) begin
        exp_t e;
        if (jidai_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("strobe_unexpected_cyc", cyc, -1);
            end else begin
                e = sbq.pop_front();
                chk("strobe_cyc", cyc, e.due);
                chk("envelope", int'(envelope), e.env);
                chk("jidai_out", int'(jidai_out), e.out);
                chk("carrier_ok", int'(carrier_ok), e.ok);
            end
        end
    end

    initial begin
        int out_s;
        repeat (3) @(posedge clk_in);
        #1;
        chk("init_envelope", int'(envelope), 0);
        chk("init_jidai_out", int'(jidai_out), 0);
        chk("init_jidai_valid", int'(jidai_valid), 0);
        chk("init_carrier_ok", int'(carrier_ok), 0);
        rst = 1'b0;
        idle(2);

        // constant 1000, continuous valid
        send_block(1000, 0);
        idle(5);
        chk("t1_envelope_hold", int'(envelope), 1000);

        // alternating +/-2000, continuous then with valid toggling
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < BLK; i++) send((i % 2 == 1) ? -2000 : 2000);
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < BLK; i++) begin
                send((i % 2 == 1) ? -2000 : 2000);
                idle(1);
            end
        idle(5);

        // full-scale negative must not wrap
        send_block(-32768, 0);
        idle(5);
        chk("t3_envelope_fullscale", int'(envelope), 32767);

        // reset mid-block discards the partial block
        for (int i = 0; i < 7; i++) send(1000);
        idle(2);
        reset_pulse();
        send_block(1000, 0);
        idle(5);

        // lock acquisition and release
        send_block(100, 0);
        for (int b = 0; b < 8; b++) send_block(1000, 0);
        idle(5);
        chk("t5_locked", int'(carrier_ok), 1);
        for (int b = 0; b < 7; b++) send_block(100, 0);
        send_block(1000, 0);
        for (int b = 0; b < 7; b++) send_block(100, 0);
        idle(5);
        chk("t5_still_locked", int'(carrier_ok), 1);
        send_block(100, 0);
        idle(5);
        chk("t5_released", int'(carrier_ok), 0);

        // envelope step 0 -> 1000 from a clean state
        reset_pulse();
        send_block(1000, 0);
        idle(5);
        chk("t6_step_first", int'(jidai_out), 7);
        for (int b = 0; b < 299; b++) send_block(1000, 0);
        idle(5);
        out_s = int'($signed(jidai_out));
`ifdef AM_RX_DCBLOCK_EN
        chk("t6_settled", int'(out_s >= -1 && out_s <= 1), 1);
`else
        chk("t6_magnitude", out_s, 7);
`endif

        idle(6);
        chk("sb_drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
